// File: rtl/spi_wb_bridge_slave.sv
// spi_wb_bridge_slave: SPI mode-0 responder that turns host frames into single
// 32-bit Wishbone initiator cycles. All SPI pins are oversampled in clk.
//
// Frame: cmd byte (0x02 write, 0x03 read, other = ignore), address byte, then
//   write: 4 data bytes MSB first; read: 1 dummy byte, then 4 data bytes on MISO.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   spi_sck_i/mosi_i/csn_i  SPI inputs from the host (idle SCK low)
//   spi_miso_o/miso_oe  SPI data out and its enable (follows synchronized CS_n)
//   wb_addr/wdata/we/cyc  Wishbone initiator outputs (cyc doubles as stb)
//   wb_rdata/ack        Wishbone responses
//   stat_ovr            one-cycle pulse on read underrun or dropped write word
//
// Optional feature macro: SPI_WB_AUTOINC_EN (multi-word frames with address
// auto-increment and read prefetch). Undefined: one word per frame.
module spi_wb_bridge_slave #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_sck_i,
    input  logic          spi_mosi_i,
    input  logic          spi_csn_i,
    output logic          spi_miso_o,
    output logic          spi_miso_oe,
    output logic [AW-1:0] wb_addr,
    output logic [31:0]   wb_wdata,
    input  logic [31:0]   wb_rdata,
    output logic          wb_we,
    output logic          wb_cyc,
    input  logic          wb_ack,
    output logic          stat_ovr
);

    localparam logic [7:0] CMD_WR = 8'h02;
    localparam logic [7:0] CMD_RD = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_WBW, S_DISCARD
    } state_t;

    state_t          r_state;
    logic            r_sck_s1, r_sck_s2, r_sck_d;
    logic            r_mosi_s1, r_mosi_s2;
    logic            r_cs_s1, r_cs_s2, r_cs_d;   // active-high chip select
    logic [2:0]      r_bit_cnt;
    logic [6:0]      r_rx_sh;
    logic [1:0]      r_byte_cnt;
    logic [23:0]     r_wsh;
    logic            r_is_wr;
    logic [AW-1:0]   r_cur_addr;
    logic [AW-1:0]   r_wb_addr;
    logic [31:0]     r_wb_wdata;
    logic            r_wb_we;
    logic            r_wb_cyc;
    logic [31:0]     r_rdata;
    logic            r_rd_valid;
    logic            r_rd_stale;
    logic            r_load_pend;
    logic [31:0]     r_tx_sh;
    logic            r_miso;
    logic            r_stat_ovr;

    logic            w_sck_rise, w_sck_fall, w_cs_start, w_cs_end;
    logic            w_byte_done;
    logic [7:0]      w_byte;
    logic [AW-1:0]   w_next_addr;

    assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_d;
    assign w_cs_start  = r_cs_s2 & ~r_cs_d;
    assign w_cs_end    = ~r_cs_s2 & r_cs_d;
    assign w_byte      = {r_rx_sh, r_mosi_s2};
    assign w_byte_done = w_sck_rise & r_cs_s2 & (r_bit_cnt == 3'd7);
    assign w_next_addr = r_cur_addr + AW'(1);

    assign spi_miso_o  = r_miso;
    assign spi_miso_oe = r_cs_s2;
    assign wb_addr     = r_wb_addr;
    assign wb_wdata    = r_wb_wdata;
    assign wb_we       = r_wb_we;
    assign wb_cyc      = r_wb_cyc;
    assign stat_ovr    = r_stat_ovr;

    // Two-flop synchronizers plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_s1  <= 1'b0; r_sck_s2  <= 1'b0; r_sck_d <= 1'b0;
            r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
            r_cs_s1   <= 1'b0; r_cs_s2   <= 1'b0; r_cs_d  <= 1'b0;
        end else begin
            r_sck_s1  <= spi_sck_i;  r_sck_s2  <= r_sck_s1;  r_sck_d <= r_sck_s2;
            r_mosi_s1 <= spi_mosi_i; r_mosi_s2 <= r_mosi_s1;
            r_cs_s1   <= ~spi_csn_i; r_cs_s2   <= r_cs_s1;   r_cs_d  <= r_cs_s2;
        end
    end

    // Bit counter and receive shifter, held clear while deselected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 3'd0;
            r_rx_sh   <= 7'd0;
        end else if (!r_cs_s2) begin
            r_bit_cnt <= 3'd0;
        end else if (w_sck_rise) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_rx_sh   <= w_byte[6:0];
        end
    end

    // Frame FSM, Wishbone initiator and MISO shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 2'd0;
            r_wsh       <= 24'd0;
            r_is_wr     <= 1'b0;
            r_cur_addr  <= '0;
            r_wb_addr   <= '0;
            r_wb_wdata  <= 32'd0;
            r_wb_we     <= 1'b0;
            r_wb_cyc    <= 1'b0;
            r_rdata     <= 32'd0;
            r_rd_valid  <= 1'b0;
            r_rd_stale  <= 1'b0;
            r_load_pend <= 1'b0;
            r_tx_sh     <= 32'd0;
            r_miso      <= 1'b0;
            r_stat_ovr  <= 1'b0;
        end else begin
            r_stat_ovr <= 1'b0;

            // Cycle completes in the clk where ack is seen; stale reads are dropped
            if (r_wb_cyc && wb_ack) begin
                r_wb_cyc <= 1'b0;
                if (!r_wb_we) begin
                    if (r_rd_stale) begin
                        r_rd_stale <= 1'b0;
                    end else begin
                        r_rdata    <= wb_rdata;
                        r_rd_valid <= 1'b1;
                    end
                end
            end

            if (w_cs_end) begin
                // A pending cycle must finish before new frames are accepted
                r_miso  <= 1'b0;
                r_state <= r_wb_cyc ? S_DISCARD : S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_start) begin
                            r_state    <= S_CMD;
                            r_byte_cnt <= 2'd0;
                            r_rd_valid <= 1'b0;
                            r_miso     <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (w_byte_done) begin
                            r_is_wr <= (w_byte == CMD_WR);
                            r_state <= (w_byte == CMD_WR || w_byte == CMD_RD) ? S_ADDR : S_DISCARD;
                        end
                    end
                    S_ADDR: begin
                        if (w_byte_done) begin
                            r_cur_addr <= w_byte[AW-1:0];
                            r_byte_cnt <= 2'd0;
                            if (r_is_wr) begin
                                r_state <= S_WDATA;
                            end else begin
                                r_state     <= S_DUMMY;
                                r_wb_addr   <= w_byte[AW-1:0];
                                r_wb_we     <= 1'b0;
                                r_wb_cyc    <= 1'b1;
                                r_load_pend <= 1'b1;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_byte_done) begin
                            r_wsh      <= {r_wsh[15:0], w_byte};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
`ifdef SPI_WB_AUTOINC_EN
                                if (r_wb_cyc) begin
                                    r_stat_ovr <= 1'b1;
                                end else begin
                                    r_wb_addr  <= r_cur_addr;
                                    r_wb_wdata <= {r_wsh, w_byte};
                                    r_wb_we    <= 1'b1;
                                    r_wb_cyc   <= 1'b1;
                                    r_cur_addr <= w_next_addr;
                                end
`else
                                r_wb_addr  <= r_cur_addr;
                                r_wb_wdata <= {r_wsh, w_byte};
                                r_wb_we    <= 1'b1;
                                r_wb_cyc   <= 1'b1;
                                r_state    <= S_WBW;
`endif
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (w_byte_done) begin
                            r_state    <= S_RDATA;
                            r_byte_cnt <= 2'd0;
                        end
                    end
                    S_RDATA: begin
                        if (w_sck_fall) begin
                            if (r_load_pend) begin
                                // First falling edge of a word: load data or signal underrun
                                r_load_pend <= 1'b0;
                                r_rd_valid  <= 1'b0;
                                if (r_rd_valid) begin
                                    r_miso  <= r_rdata[31];
                                    r_tx_sh <= {r_rdata[30:0], 1'b0};
                                end else begin
                                    r_miso     <= 1'b1;
                                    r_tx_sh    <= '1;
                                    r_stat_ovr <= 1'b1;
                                end
`ifdef SPI_WB_AUTOINC_EN
                                if (!r_wb_cyc) begin
                                    r_wb_addr  <= w_next_addr;
                                    r_wb_we    <= 1'b0;
                                    r_wb_cyc   <= 1'b1;
                                    r_cur_addr <= w_next_addr;
                                end else if (!r_rd_valid) begin
                                    r_rd_stale <= ~wb_ack;
                                end
`endif
                            end else begin
                                r_miso  <= r_tx_sh[31];
                                r_tx_sh <= {r_tx_sh[30:0], 1'b0};
                            end
                        end
                        if (w_byte_done) begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'd3) begin
`ifdef SPI_WB_AUTOINC_EN
                                r_load_pend <= 1'b1;
`else
                                r_state <= S_DISCARD;
`endif
                            end
                        end
                    end
                    S_WBW: begin
                        if (r_wb_cyc && wb_ack) begin
                            r_state <= S_DISCARD;
                        end
                    end
                    S_DISCARD: begin
                        if (w_sck_fall) begin
                            r_miso <= 1'b0;
                        end
                        if (!r_cs_s2 && !r_wb_cyc) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_wb_bridge_slave.sv
// Table-driven bench for spi_wb_bridge_slave: SPI host at clk/8, Wishbone slave
// model with programmable ack delay, plus abort / reset / auto-increment sequences.
module tb_spi_wb_bridge_slave;

    localparam int AW   = 4;
    localparam int HALF = 4;
`ifdef SPI_WB_AUTOINC_EN
    localparam int AUTO = 1;
`else
    localparam int AUTO = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          spi_sck_i, spi_mosi_i, spi_csn_i;
    logic          spi_miso_o, spi_miso_oe;
    logic [AW-1:0] wb_addr;
    logic [31:0]   wb_wdata, wb_rdata;
    logic          wb_we, wb_cyc, wb_ack, stat_ovr;

    spi_wb_bridge_slave #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sck_i(spi_sck_i), .spi_mosi_i(spi_mosi_i), .spi_csn_i(spi_csn_i),
        .spi_miso_o(spi_miso_o), .spi_miso_oe(spi_miso_oe),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack), .stat_ovr(stat_ovr)
    );

    always #5 clk = ~clk;

    // Wishbone slave model: acks after ack_delay clocks and logs each cycle
    int            ack_delay;
    logic [31:0]   rd_value;
    int            ack_cnt;
    int            log_n = 0;
    logic [AW-1:0] log_addr  [64];
    logic          log_we    [64];
    logic [31:0]   log_wdata [64];
    int            ovr_n = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_rdata <= 32'd0;
            ack_cnt  <= 0;
        end else if (wb_cyc && !wb_ack) begin
            if (ack_cnt >= ack_delay) begin
                wb_ack   <= 1'b1;
                wb_rdata <= rd_value;
                ack_cnt  <= 0;
                log_addr[log_n % 64]  <= wb_addr;
                log_we[log_n % 64]    <= wb_we;
                log_wdata[log_n % 64] <= wb_wdata;
                log_n <= log_n + 1;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            wb_ack <= 1'b0;
        end
    end

    always @(posedge clk) if (stat_ovr) ovr_n <= ovr_n + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi_i = tx[i];
            repeat (HALF) @(posedge clk);
            #1;
            rx[i] = spi_miso_o;
            spi_sck_i = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
            spi_sck_i = 1'b0;
        end
    endtask

    logic [7:0] tx_buf [10];
    logic [7:0] rx_buf [10];
    logic       oe_start;

    task automatic spi_frame(input int n);
        spi_csn_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        oe_start = spi_miso_oe;
        for (int b = 0; b < n; b++) spi_byte(tx_buf[b], rx_buf[b]);
        repeat (HALF) @(posedge clk);
        #1;
        spi_csn_i = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (wb_cyc && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check({name, " idle"}, 64'(wb_cyc), 64'd0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] data;
        int          delay;
        int          nbytes;
        int          exp_cycles;
        logic [7:0]  exp_addr;
        logic        exp_we;
        logic [63:0] exp_miso;
        int          exp_ovr;
    } vec_t;

    vec_t       vecs [7];
    vec_t       v;
    int         base_log, base_ovr;
    logic [63:0] obs;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        spi_sck_i = 1'b0; spi_mosi_i = 1'b0; spi_csn_i = 1'b1;
        rst_n = 1'b0; ack_delay = 0; rd_value = 32'd0;

        vecs[0] = '{8'h02, 8'h05, 32'hDEADBEEF, 2,   6, 1,            8'h05, 1'b1, 64'h0,                   0};
        vecs[1] = '{8'h03, 8'h0A, 32'h12345678, 3,   7, 1 + 2 * AUTO, 8'h0A, 1'b0, 64'h0000_0000_1234_5678, 0};
        vecs[2] = '{8'h03, 8'h03, 32'h0BADF00D, 100, 7, 1 + AUTO,     8'h03, 1'b0, 64'h0000_0000_FFFF_FFFF, 1 + AUTO};
        vecs[3] = '{8'h7F, 8'h02, 32'h02030405, 0,   8, 0,            8'h00, 1'b0, 64'h0,                   0};
        vecs[4] = '{8'h02, 8'h1F, 32'h00000001, 0,   6, 1,            8'h0F, 1'b1, 64'h0,                   0};
        vecs[5] = '{8'h03, 8'h00, 32'hA55A3CC3, 0,   7, 1 + 2 * AUTO, 8'h00, 1'b0, 64'h0000_0000_A55A_3CC3, 0};
        vecs[6] = '{8'h00, 8'h03, 32'h03030303, 1,   8, 0,            8'h00, 1'b0, 64'h0,                   0};

        repeat (5) @(posedge clk);
        #1;
        check("reset ctl", {59'd0, wb_cyc, spi_miso_oe, spi_miso_o, stat_ovr, wb_we}, 64'd0);
        check("reset bus", {28'd0, wb_addr, wb_wdata}, 64'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            tx_buf[0] = v.cmd;
            tx_buf[1] = v.addr;
            for (int k = 2; k < 10; k++) tx_buf[k] = 8'(8'h40 + k);
            if (v.cmd == 8'h02 || i == 3) begin
                tx_buf[2] = v.data[31:24]; tx_buf[3] = v.data[23:16];
                tx_buf[4] = v.data[15:8];  tx_buf[5] = v.data[7:0];
            end
            base_log = log_n;
            base_ovr = ovr_n;
            ack_delay = v.delay;
            rd_value = v.data;
            spi_frame(v.nbytes);
            wait_idle($sformatf("v%0d", i));
            obs = 64'd0;
            for (int b = 0; b < v.nbytes; b++) obs = {obs[55:0], rx_buf[b]};
            check($sformatf("v%0d cycles", i), 64'(log_n - base_log), 64'(v.exp_cycles));
            if (v.exp_cycles > 0) begin
                check($sformatf("v%0d addr", i), 64'(log_addr[base_log % 64]), 64'(v.exp_addr[AW-1:0]));
                check($sformatf("v%0d we", i), 64'(log_we[base_log % 64]), 64'(v.exp_we));
                if (v.exp_we) check($sformatf("v%0d wdata", i), 64'(log_wdata[base_log % 64]), 64'(v.data));
            end
            check($sformatf("v%0d miso", i), obs, v.exp_miso);
            check($sformatf("v%0d ovr", i), 64'(ovr_n - base_ovr), 64'(v.exp_ovr));
            check($sformatf("v%0d oe_on", i), 64'(oe_start), 64'd1);
            check($sformatf("v%0d oe_off", i), 64'(spi_miso_oe), 64'd0);
        end

        // Abort after two data bytes, then a full write must still work
        base_log = log_n;
        ack_delay = 1;
        tx_buf[0] = 8'h02; tx_buf[1] = 8'h02; tx_buf[2] = 8'hAA; tx_buf[3] = 8'hBB;
        spi_frame(4);
        wait_idle("abort");
        check("abort cycles", 64'(log_n - base_log), 64'd0);
        tx_buf[0] = 8'h02; tx_buf[1] = 8'h06; tx_buf[2] = 8'hCA;
        tx_buf[3] = 8'hFE; tx_buf[4] = 8'hF0; tx_buf[5] = 8'h0D;
        spi_frame(6);
        wait_idle("post_abort");
        check("post_abort cycles", 64'(log_n - base_log), 64'd1);
        check("post_abort addr", 64'(log_addr[base_log % 64]), 64'h6);
        check("post_abort wdata", 64'(log_wdata[base_log % 64]), 64'hCAFEF00D);

        // Reset asserted while a read cycle is outstanding
        ack_delay = 100;
        spi_csn_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        spi_byte(8'h03, rx_buf[0]);
        spi_byte(8'h0A, rx_buf[1]);
        check("rst_mid cyc_before", 64'(wb_cyc), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid ctl", {60'd0, wb_cyc, spi_miso_oe, spi_miso_o, stat_ovr}, 64'd0);
        spi_csn_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

`ifdef SPI_WB_AUTOINC_EN
        // Two-word write wraps the address from 0x0F to 0x00
        base_log = log_n;
        ack_delay = 2;
        tx_buf[0] = 8'h02; tx_buf[1] = 8'h0F;
        tx_buf[2] = 8'h11; tx_buf[3] = 8'h22; tx_buf[4] = 8'h33; tx_buf[5] = 8'h44;
        tx_buf[6] = 8'h55; tx_buf[7] = 8'h66; tx_buf[8] = 8'h77; tx_buf[9] = 8'h88;
        spi_frame(10);
        wait_idle("autoinc");
        check("autoinc cycles", 64'(log_n - base_log), 64'd2);
        check("autoinc addr0", 64'(log_addr[base_log % 64]), 64'hF);
        check("autoinc data0", 64'(log_wdata[base_log % 64]), 64'h11223344);
        check("autoinc addr1", 64'(log_addr[(base_log + 1) % 64]), 64'h0);
        check("autoinc data1", 64'(log_wdata[(base_log + 1) % 64]), 64'h55667788);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_wb_bridge_slave.md
# spi_wb_bridge_slave

SPI responder (mode 0) built in fabric that turns SPI frames from an external host into single 32-bit Wishbone initiator cycles. All SPI pins are oversampled in the system clock domain. It is the far end of the SB_SPI-based master wrapper: one board's SPI master can drive this block on another FPGA to reach its CSR bus.

## Interface
- `AW`, default 4: Wishbone address width, 1..8. Taken from the low `AW` bits of the address byte.
- `clk`  in  1  system clock; all logic is in this domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `spi_sck_i`  in  1  SPI clock from the host. Idle low, maximum frequency clk/8.
- `spi_mosi_i`  in  1  host-to-device data, sampled on SCK rising edges.
- `spi_csn_i`  in  1  chip select, active low.
- `spi_miso_o`  out  1  device-to-host data, updated after SCK falling edges.
- `spi_miso_oe`  out  1  MISO output enable; high while synchronized CS_n is low.
- `wb_addr`  out  AW  Wishbone address.
- `wb_wdata`  out  32  write data.
- `wb_rdata`  in  32  read data, valid with `wb_ack`.
- `wb_we`  out  1  write enable.
- `wb_cyc`  out  1  cycle and strobe combined.
- `wb_ack`  in  1  cycle acknowledge.
- `stat_ovr`  out  1  one-cycle pulse when a word is dropped or was not ready in time.

## Operation
**Input sampling**
- SCK, MOSI and CS_n each pass through a 2-FF synchronizer.
- Edges of SCK and CS_n are detected from the synchronized value and the one before it.
- MOSI is sampled on the detected SCK rising edge, MSB first.
- A bit counter (0..7) clears whenever CS_n is high.

**Frame format**
- Byte 0 is the command: 0x02 = write, 0x03 = read, anything else = ignore.
- Byte 1 is the address.
- Write frame: four data bytes follow, MSB first (D[31:24] first).
- Read frame: one dummy byte, then four data bytes on MISO, MSB first.

**FSM states**
- IDLE → CMD on CS_n falling edge.
- CMD → ADDR on command 0x02 or 0x03; CMD → DISCARD on any other value.
- ADDR → WDATA (write) or DUMMY (read).
- WDATA → WBW after the 4th byte.
- DUMMY → RDATA after 8 bits.
- RDATA → DISCARD after 32 bits.
- WBW → DISCARD on `wb_ack`.
- A CS_n rising edge in any state → IDLE, except while a Wishbone cycle is pending.

**Wishbone cycles**
- `wb_cyc` rises one clk after the cycle is requested and holds until the clk in which `wb_ack` is seen. It falls on the following clk.
- `wb_addr`, `wb_we` and `wb_wdata` are stable for the whole cycle.
- Read: the cycle is issued when the address byte completes; `wb_rdata` is latched on `wb_ack`.
- If data is not latched by the first SCK falling edge of the data phase, MISO sends 0xFFFFFFFF and `stat_ovr` pulses once.
- Write: the cycle is issued only after all 32 data bits arrive. A partial word at CS_n rise is discarded and no cycle is issued.

**MISO**
- Outputs 0 during the command, address and dummy bytes.
- Shift register advances on each detected SCK falling edge.

**Reset and abort**
- While `rst_n` is low, all outputs are 0 and the FSM is IDLE.
- A CS_n rise mid-cycle keeps `wb_cyc` asserted until `wb_ack`. Read data from that cycle is dropped. The FSM then returns to IDLE, and new CS_n falls are ignored until it does.

## Timing
- Pin to internal detected edge: 3 clk.
- MISO update: 4 clk after the SCK pin falling edge. SCK half-period must be at least 4 clk (hence SCK ≤ clk/8).
- Read: a Wishbone read slave has at least (8 dummy bits × 8 clk − 6) clk to ack before underrun.
- Write: `wb_cyc` asserts 1 clk after the internal rising edge of the 32nd data bit.
- `spi_miso_oe` follows synchronized CS_n, so it lags the pin by 2 clk.

## Configuration
- Macro: `SPI_WB_AUTOINC_EN`.
- **Defined:**
  - Write frames continue past 4 data bytes. Each further complete word issues a write at address+1, wrapping modulo 2^AW.
  - If a word completes while the previous write is still pending, the new word is dropped and `stat_ovr` pulses.
  - Read frames prefetch address+1 as soon as the current word is loaded into the MISO shifter. RDATA then repeats until CS_n rises instead of going to DISCARD.
- **Not defined:** exactly one word per frame; extra bytes are ignored (DISCARD).

## Test plan
- Write: cmd 0x02, addr 0x05, data 0xDEADBEEF, ack after 2 clk → one cycle with wb_addr=5, wb_we=1, wb_wdata=0xDEADBEEF; `stat_ovr`=0.
- Read: cmd 0x03, addr 0x0A, slave returns 0x12345678 after 3 clk → MISO bytes 0x00,0x00,0x00,0x12,0x34,0x56,0x78; exactly one read cycle.
- Read underrun: slave acks 100 clk late at SCK=clk/8 → MISO data 0xFFFFFFFF, one `stat_ovr` pulse, `wb_cyc` still completes.
- Abort: write frame with CS_n rising after 2 data bytes → no Wishbone cycle; next full write frame works normally.
- Bad command 0x7F followed by 6 bytes → no cycle, MISO stays 0.
- Reset: assert `rst_n` low mid-read → `wb_cyc`=0, `spi_miso_oe`=0 immediately. With `SPI_WB_AUTOINC_EN`, an 8-byte write at addr 0x0F, AW=4 → writes to 0x0F, then 0x00.
